// File: rtl/branch_resolve.sv
// EX-stage branch resolution: detects mispredicts, issues a one-cycle fetch
// redirect, trains a table of 2-bit direction counters and keeps branch statistics.
module branch_resolve #(
  parameter int WIDTH       = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             compare_result,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_target,
  input  logic             stall,
  input  logic [WIDTH-1:0] if_pc,
  output logic             if_pred_taken,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic             redirect_valid_q, redirect_valid_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];

  logic             resolve;
  logic             actual_taken;
  logic             mispredict;
  logic [WIDTH-1:0] correct_pc;
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] if_idx;
  logic             unused_if_pc;

  assign ex_idx       = ex_pc[IDX_W+1:2];
  assign if_idx       = if_pc[IDX_W+1:2];
  assign unused_if_pc = ^if_pc;

  // A branch arriving while a redirect is pending is on the wrong path.
  assign resolve      = ex_valid && ex_branch && !stall && !redirect_valid_q;
  assign actual_taken = compare_result;
  assign correct_pc   = actual_taken ? ex_target : ex_pc + WIDTH'(4);
  assign mispredict   = (actual_taken != ex_pred_taken) ||
                        (actual_taken && ex_pred_taken && (ex_pred_target != ex_target));

  always_comb begin
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;
    bht_d            = bht_q;
    if (resolve) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispredict) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = correct_pc;
        if (mispred_cnt_q != 32'hFFFF_FFFF) mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
      if (actual_taken) begin
        if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
      bht_q            <= bht_d;
    end
  end

  // Reads see the registered table, so a same-cycle write shows up next cycle.
  assign if_pred_taken  = bht_q[if_idx][1];
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule
